led_line_shifter: RTL and testbench

LED_LINE_SHIFTER -- requirements
Module: led_line_shifter

---
 rtl/led_matrix_pkg.sv | 29 ++
 rtl/led_line_shifter_mux.sv | 29 ++
 rtl/led_line_shifter.sv | 117 +++++++++++
 tb/tb_led_line_shifter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants, RAM word layout and FSM encoding for the LED matrix.
package led_matrix_pkg;

  localparam int NUM_COLS = 64;
  localparam int NUM_ROWS = 24;
  localparam int PWM_BITS = 4;

  localparam int COL_W  = 6;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int PWM_W  = 4;

  // Field slots within a RAM word, in units of PWM_BITS, r0 highest.
  localparam int R0_FLD = 5;
  localparam int G0_FLD = 4;
  localparam int B0_FLD = 3;
  localparam int R1_FLD = 2;
  localparam int G1_FLD = 1;
  localparam int B1_FLD = 0;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SETUP,
    CLOCK,
    DONE
  } state_t;

endpackage

// File: rtl/led_line_shifter_mux.sv
// Bit-plane extraction: picks bit [pwm] of every colour field of a RAM word.
module led_bitplane_mux
  import led_matrix_pkg::*;
#(
  parameter int PWM_BITS = led_matrix_pkg::PWM_BITS
) (
  input  logic [6*PWM_BITS-1:0] word,
  input  logic [PWM_W-1:0]      pwm,
  output logic [2:0]            rgb0,
  output logic [2:0]            rgb1
);

  // An out-of-range plane matches no index and leaves both outputs dark.
  always_comb begin
    rgb0 = '0;
    rgb1 = '0;
    for (int i = 0; i < PWM_BITS; i++) begin
      if (pwm == PWM_W'(i)) begin
        rgb0 = {word[R0_FLD*PWM_BITS+i],
                word[G0_FLD*PWM_BITS+i],
                word[B0_FLD*PWM_BITS+i]};
        rgb1 = {word[R1_FLD*PWM_BITS+i],
                word[G1_FLD*PWM_BITS+i],
                word[B1_FLD*PWM_BITS+i]};
      end
    end
  end

endmodule

// File: rtl/led_line_shifter.sv
// Shifts one matrix line (upper+lower half) out to the panel, 3 clocks/pixel.
// Build option: LED_SHIFT_COL_REVERSE_EN reads columns right to left.
module led_line_shifter
  import led_matrix_pkg::*;
#(
  parameter int NUM_COLS = led_matrix_pkg::NUM_COLS,
  parameter int NUM_ROWS = led_matrix_pkg::NUM_ROWS,
  parameter int PWM_BITS = led_matrix_pkg::PWM_BITS
) (
  input  logic                  clk_25MHz,
  input  logic                  rst_n,
  input  logic                  line_begin,
  input  logic [ROW_W-1:0]      line_addr,
  input  logic [PWM_W-1:0]      line_pwm,
  output logic                  line_done,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_rd_en,
  input  logic [6*PWM_BITS-1:0] ram_rdata,
  output logic [2:0]            rgb0,
  output logic [2:0]            rgb1,
  output logic                  sclk
);

  // Rows beyond the 5-bit field cannot be addressed.
  if (NUM_ROWS > (1 << ROW_W)) begin : g_rows_exceed_field
  end

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PWM_W-1:0] pwm;
  logic [2:0]       rgb0_q;
  logic [2:0]       rgb1_q;
  logic [2:0]       mux0;
  logic [2:0]       mux1;

  function automatic logic [COL_W-1:0] col_field(
    input logic [COL_W-1:0] c
  );
`ifdef LED_SHIFT_COL_REVERSE_EN
    return LAST_COL - c;
`else
    return c;
`endif
  endfunction

  led_bitplane_mux #(
    .PWM_BITS (PWM_BITS)
  ) u_mux (
    .word (ram_rdata),
    .pwm  (pwm),
    .rgb0 (mux0),
    .rgb1 (mux1)
  );

  // Data flows through in SETUP so it is a full cycle ahead of sclk.
  assign rgb0 = (state == SETUP) ? mux0 : rgb0_q;
  assign rgb1 = (state == SETUP) ? mux1 : rgb1_q;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      pwm       <= '0;
      sclk      <= 1'b0;
      line_done <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      rgb0_q    <= '0;
      rgb1_q    <= '0;
    end else begin
      line_done <= 1'b0;
      ram_rd_en <= 1'b0;
      sclk      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (line_begin) begin
            row       <= line_addr;
            pwm       <= line_pwm;
            col       <= '0;
            ram_rd_en <= 1'b1;
            ram_addr  <= {line_addr, col_field('0)};
            state     <= READ;
          end
        end
        READ: begin
          state <= SETUP;
        end
        SETUP: begin
          rgb0_q <= mux0;
          rgb1_q <= mux1;
          sclk   <= 1'b1;
          state  <= CLOCK;
        end
        CLOCK: begin
          if (col == LAST_COL) begin
            line_done <= 1'b1;
            state     <= DONE;
          end else begin
            col       <= col + 1'b1;
            ram_rd_en <= 1'b1;
            ram_addr  <= {row, col_field(col + 1'b1)};
            state     <= READ;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_line_shifter.sv
// Bench for led_line_shifter: line table, scoreboard queues, reset abort.
module tb_led_line_shifter;

  localparam int COLS    = 64;
  localparam int DONE_AT = 3 * COLS + 1;

  logic        clk_25MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_begin = 1'b0;
  logic [4:0]  line_addr = '0;
  logic [3:0]  line_pwm = '0;
  logic        line_done;
  logic [10:0] ram_addr;
  logic        ram_rd_en;
  logic [23:0] ram_rdata = '0;
  logic [2:0]  rgb0;
  logic [2:0]  rgb1;
  logic        sclk;

  led_line_shifter dut (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .line_begin(line_begin),
    .line_addr (line_addr),
    .line_pwm  (line_pwm),
    .line_done (line_done),
    .ram_addr  (ram_addr),
    .ram_rd_en (ram_rd_en),
    .ram_rdata (ram_rdata),
    .rgb0      (rgb0),
    .rgb1      (rgb1),
    .sclk      (sclk)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct {
    logic [4:0]  addr;
    logic [3:0]  pwm;
    bit          hash;
    logic [23:0] pat;
    bit          inj;
  } vec_t;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_at = 0;
  int done_cnt = 0;
  int sclk_edges = 0;
  logic sclk_prev = 1'b0;
  bit hash_mode = 1'b0;
  logic [23:0] pat = '0;
  logic [5:0] last_rgb = '0;
  logic [10:0] exp_addr_q[$];
  logic [5:0]  exp_rgb_q[$];

  always @(posedge clk_25MHz) cyc++;

  function automatic logic [23:0] word_of(input logic [10:0] a);
    logic [23:0] h;
    h = {13'd0, a} * 24'h009E37;
    if (hash_mode) return h ^ 24'h5A5A5A;
    return pat;
  endfunction

  function automatic logic [5:0] plane(input logic [23:0] w,
                                       input logic [3:0] p);
    if (p >= 4) return 6'd0;
    return {w[20+p], w[16+p], w[12+p], w[8+p], w[4+p], w[p]};
  endfunction

  // Framebuffer model: one-cycle read latency.
  always @(posedge clk_25MHz)
    if (ram_rd_en) ram_rdata <= word_of(ram_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    vectors++;
    errs++;
    $display("FAIL %s: event with empty scoreboard at cycle %0d",
             nm, cyc);
  endtask

  always @(negedge clk_25MHz) begin
    if (ram_rd_en) begin
      if (exp_addr_q.size() == 0) unexpected("ram_addr");
      else chk("ram_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
    end
    if (sclk && !sclk_prev) begin
      sclk_edges++;
      if (exp_rgb_q.size() == 0) unexpected("rgb");
      else chk("rgb", 32'({rgb0, rgb1}), 32'(exp_rgb_q.pop_front()));
    end
    sclk_prev = sclk;
    if (line_done) begin
      done_cnt++;
      done_at = cyc - start_cyc;
    end
  end

  task automatic push_line(input logic [4:0] a, input logic [3:0] p);
    logic [5:0]  c;
    logic [10:0] ad;
    for (int i = 0; i < COLS; i++) begin
`ifdef LED_SHIFT_COL_REVERSE_EN
      c = 6'(COLS - 1 - i);
`else
      c = 6'(i);
`endif
      ad = {a, c};
      exp_addr_q.push_back(ad);
      exp_rgb_q.push_back(plane(word_of(ad), p));
      last_rgb = plane(word_of(ad), p);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sclk"}, 32'(sclk), 0);
    chk({tag, "_rd_en"}, 32'(ram_rd_en), 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_done"}, 32'(line_done), 0);
    chk({tag, "_rgb"}, 32'({rgb0, rgb1}), 0);
  endtask

  task automatic run_line(input vec_t v);
    int d0;
    hash_mode = v.hash;
    pat = v.pat;
    push_line(v.addr, v.pwm);
    sclk_edges = 0;
    d0 = done_cnt;
    @(posedge clk_25MHz);
    #1;
    line_addr = v.addr;
    line_pwm = v.pwm;
    line_begin = 1'b1;
    start_cyc = cyc;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk_25MHz);
      #1;
      line_begin = v.inj && (k == 10 || k == 100);
      if (line_begin) begin
        line_addr = 5'd9;
        line_pwm = 4'd1;
      end
      if (done_cnt != d0) break;
    end
    line_begin = 1'b0;
    repeat (4) @(posedge clk_25MHz);
    #1;
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("done_cycle", 32'(done_at), 32'(DONE_AT));
    chk("sclk_edges", 32'(sclk_edges), 32'(COLS));
    chk("addr_left", 32'(exp_addr_q.size()), 0);
    chk("rgb_left", 32'(exp_rgb_q.size()), 0);
    chk("rgb_hold", 32'({rgb0, rgb1}), 32'(last_rgb));
  endtask

  vec_t tv[7];

  initial begin
    int d0;
    tv[0] = '{5'd5,  4'd2,  1'b1, 24'h000000, 1'b0};
    tv[1] = '{5'd0,  4'd3,  1'b0, 24'hF0F0F0, 1'b0};
    tv[2] = '{5'd0,  4'd0,  1'b0, 24'hF0F0F0, 1'b0};
    tv[3] = '{5'd5,  4'd2,  1'b1, 24'h000000, 1'b1};
    tv[4] = '{5'd27, 4'd1,  1'b1, 24'h000000, 1'b0};
    tv[5] = '{5'd3,  4'd7,  1'b1, 24'h000000, 1'b0};
    tv[6] = '{5'd23, 4'd15, 1'b0, 24'hFFFFFF, 1'b0};

    repeat (3) @(posedge clk_25MHz);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk_25MHz);
    #1;
    chk("idle_rd_en", 32'(ram_rd_en), 0);

    for (int i = 0; i < 7; i++) run_line(tv[i]);

    // Abort a line at cycle 50 with an asynchronous reset.
    hash_mode = 1'b1;
    push_line(5'd12, 4'd1);
    d0 = done_cnt;
    @(posedge clk_25MHz);
    #1;
    line_addr = 5'd12;
    line_pwm = 4'd1;
    line_begin = 1'b1;
    start_cyc = cyc;
    @(posedge clk_25MHz);
    #1;
    line_begin = 1'b0;
    repeat (49) @(posedge clk_25MHz);
    #5;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    exp_addr_q.delete();
    exp_rgb_q.delete();
    repeat (3) @(posedge clk_25MHz);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk_25MHz);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    check_zero("post_abort");

    run_line(tv[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
